bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumes the hundreds/tens/ones BCD digits from the binary-to-BCD stage and drives a 3-digit, common-anode, time-multiplexed seven-segment display.
- Holds a shadow copy of the digits, commits it only at frame boundaries so the display never tears, and blanks all anodes briefly at the start of each digit slot to suppress ghosting.
- Optionally blanks leading zeros.

Parameters:
- DWELL_CYCLES, 27000: clock cycles per digit slot (1 ms at 27 MHz). Must be ≥ 2.
- BLANK_CYCLES, 270: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ BLANK_CYCLES < DWELL_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- load  in  1  1-cycle strobe: capture hundreds/tens/ones into the shadow register
- hundreds  in  4  BCD digit
- tens  in  4  BCD digit
- ones  in  4  BCD digit
- blank_lz  in  1  1 = suppress leading zeros (sampled every cycle)
- an  out  3  anode enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds
- seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
- frame_tick  out  1  1-cycle pulse at the start of each frame (ones slot)

Behaviour:
- Interface: one clock, clk. Reset reset_n is synchronous and active-low; all state is sampled on the rising edge of clk.
- Reset values:
  - cnt=0, slot=0
  - shadow and active digit registers = 0, pending=0
  - an=3'b111, seg=7'h7F, frame_tick=0
- Counter: cnt counts 0..DWELL_CYCLES-1. At DWELL_CYCLES-1 it returns to 0 and slot advances 0→1→2→0. The 2→0 step is a "wrap".
- Load and commit:
  - load=1 writes the shadow register and sets pending=1.
  - On a wrap with pending=1: active←shadow (the value held before this edge), and pending←0.
  - If load and a wrap coincide, the old shadow is committed, the new inputs go into the shadow, and pending stays 1. The new value is therefore committed at the following wrap.
  - Back-to-back loads: the last one wins.
- Outputs are registered. an, seg and frame_tick are computed from the current cnt, slot and active registers, so they appear 1 cycle later.
- Anode drive:
  - If cnt < BLANK_CYCLES: an=3'b111 and seg=7'h7F.
  - Otherwise: an = ~(3'b001 << slot).
- Digit selection: the slot picks the active digit (0=ones, 1=tens, 2=hundreds).
- Leading-zero blanking (blank_lz=1):
  - The hundreds slot shows blank if hundreds==0.
  - The tens slot shows blank if hundreds==0 and tens==0.
  - Ones is never blanked, so a value of 0 displays "0".
  - A blanked slot still drives its anode, with seg=7'h7F.
- Segment codes (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - digit 10–15 = dash 3F; blank = 7F
  - An invalid nonzero hundreds digit is never treated as a leading zero.
- frame_tick: output is 1 exactly in the cycle after cnt==0 and slot==0. It fires once per 3·DWELL_CYCLES cycles.
- Reset mid-frame: everything returns to reset values on the next edge, and any pending shadow is discarded. The first frame_tick after release appears 1 cycle after the first edge with reset_n=1.
- Width: cnt is $clog2(DWELL_CYCLES) bits; slot is 2 bits, and the value 3 is unreachable.

Decomposition:
- Package bcd_display_pkg:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F
  - the 10-entry digit-to-segment constant table
  - slot index constants SLOT_ONES/SLOT_TENS/SLOT_HUNDREDS
- Sub-module seg7_decode: combinational 4-bit digit + blank flag → 7-bit active-low seg, using the package table.
- Scanner top holds the counter, slot, shadow/active registers and the output registers.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2):
1. Reset held 5 cycles, then released with no load:
   - an=111 and seg=7F throughout reset.
   - After reset, the ones slot shows seg=40 on an=110 during cnt 2..7.
   - frame_tick pulses every 24 cycles.
2. load with {1,2,3}, then run 2 frames:
   - Old digits persist until the wrap.
   - From the next frame: an=110→seg=30, an=101→seg=24, an=011→seg=79.
   - 2-cycle all-off gap at each slot start.
3. blank_lz=1 with {0,0,7}: ones shows seg=78; tens and hundreds show seg=7F with their anodes low. With {0,5,0}: hundreds=7F, tens=12, ones=40.
4. load {9,9,9} on the exact wrap cycle, shadow previously {4,5,6}:
   - The next frame shows 4,5,6.
   - The frame after shows 9,9,9 (seg=10 in all slots).
5. load {0xC,0,0} with blank_lz=1: hundreds shows dash 3F, not blanked; tens shows 40 and ones shows 40.
6. Pending load, then reset_n=0 for 1 cycle mid-slot: outputs go to an=111/seg=7F. The display resumes with 0s and the pending value never appears.

Source files
------------

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the 3-digit seven-segment scanner: segment codes
// (active-low, bit order gfedcba) and slot indices.
package bcd_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry n is the pattern for BCD digit n; listed from 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [1:0] SLOT_ONES     = 2'd0;
    localparam logic [1:0] SLOT_TENS     = 2'd1;
    localparam logic [1:0] SLOT_HUNDREDS = 2'd2;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit input and display output bundle between the BCD stage and the scanner.
interface bcd_display_scanner_if;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic [2:0] an;
    logic [6:0] seg;
    logic       frame_tick;

    modport master (
        output load, hundreds, tens, ones, blank_lz,
        input  an, seg, frame_tick
    );

    modport slave (
        input  load, hundreds, tens, ones, blank_lz,
        output an, seg, frame_tick
    );
endinterface

// File: rtl/bcd_display_scanner_seg7_decode.sv
// Combinational digit to active-low segment decoder; codes above 9 show a dash.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            if (digit > 4'd9) begin
                seg = SEG_DASH;
            end else begin
                seg = SEG_TABLE[digit];
            end
        end
    end
endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit common-anode scanner with frame-aligned digit commit,
// per-slot anti-ghosting blanking and optional leading-zero suppression.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 27000,
    parameter int BLANK_CYCLES = 270
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bcd_display_scanner_if.slave bus
);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       slot_reg, slot_next;
    logic [2:0][3:0]  shadow_reg, shadow_next;
    logic [2:0][3:0]  active_reg, active_next;
    logic             pending_reg, pending_next;
    logic [2:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             frame_tick_reg, frame_tick_next;

    logic             last_cnt;
    logic             wrap;
    logic             in_blank;
    logic [2:0]       lz_blank;
    logic [2:0][6:0]  slot_seg;

    assign last_cnt = (cnt_reg == CNT_W'(DWELL_CYCLES - 1));
    assign wrap     = last_cnt && (slot_reg == SLOT_HUNDREDS);
    assign in_blank = (cnt_reg < CNT_W'(BLANK_CYCLES));

    // A nonzero hundreds digit (even an invalid one) stops zero suppression.
    assign lz_blank[SLOT_ONES]     = 1'b0;
    assign lz_blank[SLOT_TENS]     = bus.blank_lz && (active_reg[SLOT_HUNDREDS] == 4'd0)
                                                  && (active_reg[SLOT_TENS] == 4'd0);
    assign lz_blank[SLOT_HUNDREDS] = bus.blank_lz && (active_reg[SLOT_HUNDREDS] == 4'd0);

    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
        seg7_decode u_dec (
            .digit (active_reg[gi]),
            .blank (lz_blank[gi]),
            .seg   (slot_seg[gi])
        );
    end

    always_comb begin
        cnt_next        = cnt_reg + 1'b1;
        slot_next       = slot_reg;
        shadow_next     = shadow_reg;
        active_next     = active_reg;
        pending_next    = pending_reg;
        an_next         = 3'b111;
        seg_next        = SEG_BLANK;
        frame_tick_next = (cnt_reg == '0) && (slot_reg == SLOT_ONES);

        if (last_cnt) begin
            cnt_next  = '0;
            slot_next = (slot_reg == SLOT_HUNDREDS) ? SLOT_ONES : slot_reg + 2'd1;
        end

        // Commit uses the pre-edge shadow; a coincident load stays pending.
        if (wrap && pending_reg) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
        end
        if (bus.load) begin
            shadow_next  = {bus.hundreds, bus.tens, bus.ones};
            pending_next = 1'b1;
        end

        if (!in_blank) begin
            an_next  = ~(3'b001 << slot_reg);
            seg_next = slot_seg[slot_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg        <= '0;
            slot_reg       <= SLOT_ONES;
            shadow_reg     <= '0;
            active_reg     <= '0;
            pending_reg    <= 1'b0;
            an_reg         <= 3'b111;
            seg_reg        <= SEG_BLANK;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            slot_reg       <= slot_next;
            shadow_reg     <= shadow_next;
            active_reg     <= active_next;
            pending_reg    <= pending_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed plus randomized bench for bcd_display_scanner against a frame-position
// reference model; every cycle's registered outputs are compared.
module tb_bcd_display_scanner;
    localparam int D = 8;
    localparam int B = 2;
    localparam int FRAME = 3 * D;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    bcd_display_scanner_if bus ();

    bcd_display_scanner #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: position within the frame, digits indexed 0=ones,1=tens,2=hundreds.
    int m_pos = 0;
    int m_sh[3] = '{0, 0, 0};
    int m_act[3] = '{0, 0, 0};
    bit m_pend = 1'b0;
    logic [2:0] e_an = 3'b111;
    logic [6:0] e_seg = 7'h7F;
    logic e_ft = 1'b0;
    int cyc = 0;
    int last_ft = -1;

    function automatic logic [6:0] ref_seg(int d, bit blank);
        if (blank) return 7'h7F;
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int s;
        int c;
        bit blank;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            m_pos = 0;
            m_sh = '{0, 0, 0};
            m_act = '{0, 0, 0};
            m_pend = 1'b0;
            e_an = 3'b111;
            e_seg = 7'h7F;
            e_ft = 1'b0;
            last_ft = -1;
        end else begin
            s = m_pos / D;
            c = m_pos % D;
            e_ft = (m_pos == 0);
            e_an = 3'b111;
            e_seg = 7'h7F;
            if (c >= B) begin
                e_an[s] = 1'b0;
                blank = bus.blank_lz && m_act[2] == 0 && (s == 2 || (s == 1 && m_act[1] == 0));
                e_seg = ref_seg(m_act[s], blank);
            end
            if (m_pos == FRAME - 1 && m_pend) begin
                m_act = m_sh;
                m_pend = 1'b0;
            end
            if (bus.load) begin
                m_sh = '{int'(bus.ones), int'(bus.tens), int'(bus.hundreds)};
                m_pend = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
        if (bus.frame_tick === 1'b1) begin
            if (last_ft >= 0) chk("ft_period", cyc - last_ft, FRAME);
            last_ft = cyc;
        end
    endtask

    task automatic wait_pos(int p);
        for (int i = 0; i < 2 * FRAME && m_pos != p; i++) tick();
    endtask

    task automatic do_load(int h, int t, int o);
        bus.load = 1'b1;
        bus.hundreds = 4'(h);
        bus.tens = 4'(t);
        bus.ones = 4'(o);
        tick();
        bus.load = 1'b0;
    endtask

    // Advance into the first visible cycle of slot s and check it literally.
    task automatic expect_slot(string tag, int s, logic [6:0] sg);
        logic [2:0] a;
        wait_pos(s * D + B);
        tick();
        a = 3'b111;
        a[s] = 1'b0;
        chk({tag, "_an"}, 32'(bus.an), 32'(a));
        chk({tag, "_seg"}, 32'(bus.seg), 32'(sg));
    endtask

    initial begin
        bus.load = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens = 4'd0;
        bus.ones = 4'd0;
        bus.blank_lz = 1'b0;

        // Reset held, then released with zeros shown.
        for (int i = 0; i < 5; i++) tick();
        chk("rst_an", 32'(bus.an), 32'h7);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        reset_n = 1'b1;
        tick();
        chk("first_ft", 32'(bus.frame_tick), 32'h1);
        tick();
        tick();
        chk("zero_an", 32'(bus.an), 32'h6);
        chk("zero_seg", 32'(bus.seg), 32'h40);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Load 123: old digits persist until the wrap.
        wait_pos(3);
        do_load(1, 2, 3);
        expect_slot("old_tens", 1, 7'h40);
        expect_slot("n123_ones", 0, 7'h30);
        expect_slot("n123_tens", 1, 7'h24);
        expect_slot("n123_hund", 2, 7'h79);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        do_load(0, 0, 7);
        expect_slot("lz7_ones", 0, 7'h78);
        expect_slot("lz7_tens", 1, 7'h7F);
        expect_slot("lz7_hund", 2, 7'h7F);
        do_load(0, 5, 0);
        expect_slot("lz50_ones", 0, 7'h40);
        expect_slot("lz50_tens", 1, 7'h12);
        expect_slot("lz50_hund", 2, 7'h7F);
        bus.blank_lz = 1'b0;

        // Load coinciding with the wrap while 456 is still pending.
        wait_pos(4);
        do_load(4, 5, 6);
        wait_pos(FRAME - 1);
        do_load(9, 9, 9);
        expect_slot("w456_ones", 0, 7'h02);
        expect_slot("w456_tens", 1, 7'h12);
        expect_slot("w456_hund", 2, 7'h19);
        expect_slot("w999_ones", 0, 7'h10);
        expect_slot("w999_tens", 1, 7'h10);
        expect_slot("w999_hund", 2, 7'h10);

        // Invalid hundreds digit is a dash and never a leading zero.
        bus.blank_lz = 1'b1;
        do_load(12, 0, 0);
        expect_slot("dash_ones", 0, 7'h40);
        expect_slot("dash_tens", 1, 7'h40);
        expect_slot("dash_hund", 2, 7'h3F);
        bus.blank_lz = 1'b0;

        // Reset mid-slot discards a pending load.
        wait_pos(D + 4);
        do_load(8, 8, 8);
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_an", 32'(bus.an), 32'h7);
        chk("midrst_seg", 32'(bus.seg), 32'h7F);
        reset_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            expect_slot("post_ones", 0, 7'h40);
            expect_slot("post_tens", 1, 7'h40);
            expect_slot("post_hund", 2, 7'h40);
        end

        // Randomized loads, blanking toggles and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            bus.hundreds = 4'($urandom_range(0, 15));
            bus.tens = 4'($urandom_range(0, 15));
            bus.ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                bus.hundreds = 4'd0;
                if ($urandom_range(0, 1) == 0) bus.tens = 4'd0;
            end
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
